grid_io_tile_cfg: RTL and testbench

//  Parametrised perimeter I/O tile: NUM_GPIO bidirectional pads, NUM_GPIN input-only pads and NUM_GPOUT output-only pads.
//  - Bidirectional pads are configured through a gated configuration chain (ccff_head -> ccff_tail) with a shift counter and a done flag.
//  - Configuration is held in a shadow register; pads stay tri-stated until configuration completes.
//  - Inputs have optional per-pad synchronisation and polarity inversion.

---
 rtl/grid_io_pkg.sv | 12 +
 rtl/io_in_sync.sv | 30 +++
 rtl/grid_io_tile_cfg.sv | 124 ++++++++++++
 tb/tb_grid_io_tile_cfg.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/grid_io_pkg.sv
// rtl/grid_io_pkg.sv - shared configuration slice layout for the perimeter I/O tile
package grid_io_pkg;

    // Width of one bidirectional pad configuration slice
    localparam int CFG_W    = 3;

    // Bit positions inside a slice
    localparam int CFG_OE   = 0;
    localparam int CFG_SYNC = 1;
    localparam int CFG_INV  = 2;

endpackage

// File: rtl/io_in_sync.sv
// rtl/io_in_sync.sv - multi-flop input synchroniser with asynchronous active-low clear
module io_in_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff_q;
    logic [STAGES-1:0] ff_d;

    // Advance the sample one stage per edge; the oldest stage is the output
    always_comb begin
        ff_d = {ff_q[STAGES-2:0], d};
    end

    // Synchroniser flops, cleared immediately on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_q <= '0;
        end else begin
            ff_q <= ff_d;
        end
    end

    assign q = ff_q[STAGES-1];

endmodule

// File: rtl/grid_io_tile_cfg.sv
// rtl/grid_io_tile_cfg.sv - perimeter I/O tile with serial configuration chain and shadow register
module grid_io_tile_cfg
    import grid_io_pkg::*;
#(
    parameter int NUM_GPIO    = 8,
    parameter int NUM_GPIN    = 8,
    parameter int NUM_GPOUT   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 prog_clk,
    input  logic                 pReset,
    inout  wire  [NUM_GPIO-1:0]  gfpga_pad_GPIO_PAD,
    input  logic [NUM_GPIN-1:0]  gfpga_pad_GPIN_PAD,
    output logic [NUM_GPOUT-1:0] gfpga_pad_GPOUT_PAD,
    input  logic [NUM_GPIO-1:0]  io_outpad,
    output logic [NUM_GPIO-1:0]  io_inpad,
    output logic [NUM_GPIN-1:0]  gp_inpad,
    input  logic [NUM_GPOUT-1:0] gp_outpad,
    input  logic                 ccff_head,
    input  logic                 ccff_shift_en,
    input  logic                 cfg_restart,
    output logic                 ccff_tail,
    output logic                 cfg_done
);

    localparam int CHAIN_LEN = NUM_GPIO * CFG_W;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1);

    logic [CHAIN_LEN-1:0] chain_q,  chain_d;
    logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic                 done_q,   done_d;
    logic                 locked_q, locked_d;

    logic [NUM_GPIO-1:0]  gpio_sync;

    // Next-state for chain, shift counter, done flag and shadow capture
    always_comb begin
        chain_d  = chain_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        locked_d = locked_q;
        if (cfg_restart) begin
            // Restart wins over a same-cycle shift; chain contents survive
            cnt_d    = '0;
            done_d   = 1'b0;
            shadow_d = '0;
            locked_d = 1'b0;
        end else begin
            if (ccff_shift_en) begin
                chain_d = {chain_q[CHAIN_LEN-2:0], ccff_head};
                if (cnt_q != CNT_W'(CHAIN_LEN)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            done_d = (cnt_d == CNT_W'(CHAIN_LEN));
            // Capture once, the edge after done rises, then hold until restart
            if (done_q && !locked_q) begin
                shadow_d = chain_q;
                locked_d = 1'b1;
            end
        end
    end

    // Configuration state registers
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            chain_q  <= '0;
            shadow_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            chain_q  <= chain_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            locked_q <= locked_d;
        end
    end

    assign ccff_tail = chain_q[CHAIN_LEN-1];
    assign cfg_done  = done_q;

    // Bidirectional pads: drive and return path are taken from the shadow only
    for (genvar k = 0; k < NUM_GPIO; k++) begin : g_gpio
        logic [CFG_W-1:0] slice;
        logic             pad_in;

        assign slice = shadow_q[k*CFG_W +: CFG_W];

        assign gfpga_pad_GPIO_PAD[k] = slice[CFG_OE] ? (io_outpad[k] ^ slice[CFG_INV]) : 1'bz;

        io_in_sync #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk   (prog_clk),
            .rst_n (pReset),
            .d     (gfpga_pad_GPIO_PAD[k]),
            .q     (gpio_sync[k])
        );

        assign pad_in = slice[CFG_SYNC] ? gpio_sync[k] : gfpga_pad_GPIO_PAD[k];

        // Fabric sees 0 until a configuration has been captured
        assign io_inpad[k] = locked_q & (pad_in ^ slice[CFG_INV]);
    end

    // Input-only pads are always synchronised
    for (genvar k = 0; k < NUM_GPIN; k++) begin : g_gpin
        io_in_sync #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk   (prog_clk),
            .rst_n (pReset),
            .d     (gfpga_pad_GPIN_PAD[k]),
            .q     (gp_inpad[k])
        );
    end

    assign gfpga_pad_GPOUT_PAD = gp_outpad;

endmodule

// File: tb/tb_grid_io_tile_cfg.sv
// tb/tb_grid_io_tile_cfg.sv - directed self-checking bench for grid_io_tile_cfg
module tb_grid_io_tile_cfg;

    logic       prog_clk;
    logic       pReset;
    wire  [7:0] gpio_pad;
    logic [7:0] gpin_pad;
    wire  [7:0] gpout_pad;
    logic [7:0] io_outpad;
    wire  [7:0] io_inpad;
    wire  [7:0] gp_inpad;
    logic [7:0] gp_outpad;
    logic       ccff_head;
    logic       ccff_shift_en;
    logic       cfg_restart;
    wire        ccff_tail;
    wire        cfg_done;

    logic [7:0] ext_en;
    logic [7:0] ext_val;

    int errs;
    int checks;

    // Pull-ups make an undriven pad read 1; external drivers model off-chip sources
    for (genvar k = 0; k < 8; k++) begin : g_pad
        pullup (gpio_pad[k]);
        assign gpio_pad[k] = ext_en[k] ? ext_val[k] : 1'bz;
    end

    grid_io_tile_cfg #(
        .NUM_GPIO    (8),
        .NUM_GPIN    (8),
        .NUM_GPOUT   (8),
        .SYNC_STAGES (2)
    ) dut (
        .prog_clk            (prog_clk),
        .pReset              (pReset),
        .gfpga_pad_GPIO_PAD  (gpio_pad),
        .gfpga_pad_GPIN_PAD  (gpin_pad),
        .gfpga_pad_GPOUT_PAD (gpout_pad),
        .io_outpad           (io_outpad),
        .io_inpad            (io_inpad),
        .gp_inpad            (gp_inpad),
        .gp_outpad           (gp_outpad),
        .ccff_head           (ccff_head),
        .ccff_shift_en       (ccff_shift_en),
        .cfg_restart         (cfg_restart),
        .ccff_tail           (ccff_tail),
        .cfg_done            (cfg_done)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic shift_bit(input logic b);
        ccff_head     = b;
        ccff_shift_en = 1'b1;
        tick();
        ccff_shift_en = 1'b0;
        ccff_head     = 1'b0;
    endtask

    task automatic restart_pulse();
        cfg_restart = 1'b1;
        tick();
        cfg_restart = 1'b0;
    endtask

    // Restart, shift a full 24-bit image (MSB first) and wait for the shadow capture
    task automatic configure(input logic [23:0] w);
        restart_pulse();
        for (int i = 23; i >= 0; i--) shift_bit(w[i]);
        tick();
    endtask

    // Shift 24 zeros, collecting ccff_tail before each shift
    task automatic readback(output logic [23:0] got);
        got = '0;
        for (int i = 23; i >= 0; i--) begin
            got[i] = ccff_tail;
            shift_bit(1'b0);
        end
    endtask

    logic [23:0] rb;

    initial begin
        errs          = 0;
        checks        = 0;
        pReset        = 1'b0;
        gpin_pad      = 8'h00;
        io_outpad     = 8'h00;
        gp_outpad     = 8'h00;
        ccff_head     = 1'b0;
        ccff_shift_en = 1'b0;
        cfg_restart   = 1'b0;
        ext_en        = 8'h00;
        ext_val       = 8'h00;

        #3;
        check_eq("rst_done",     32'(cfg_done),  32'h0);
        check_eq("rst_tail",     32'(ccff_tail), 32'h0);
        check_eq("rst_io_inpad", 32'(io_inpad),  32'h00);
        check_eq("rst_gp_inpad", 32'(gp_inpad),  32'h00);
        check_eq("rst_pads_z",   32'(gpio_pad),  32'hFF);

        tick();
        pReset = 1'b1;
        tick();

        // 23 ones: not done, pads still Z; 24th completes
        io_outpad = 8'hFF;
        for (int i = 0; i < 23; i++) shift_bit(1'b1);
        check_eq("done_at_23",  32'(cfg_done), 32'h0);
        check_eq("pads_z_23",   32'(gpio_pad), 32'hFF);
        shift_bit(1'b1);
        check_eq("done_at_24",  32'(cfg_done), 32'h1);
        check_eq("pads_z_24",   32'(gpio_pad), 32'hFF);
        tick();
        check_eq("pads_drv_inv", 32'(gpio_pad), 32'h00);

        // ch3 = {INV,SYNC,OE} 001
        io_outpad = 8'h00;
        configure(24'h000200);
        check_eq("ch3_drive0",    32'(gpio_pad), 32'hF7);
        check_eq("ch3_inpad0",    32'(io_inpad), 32'hF7);
        io_outpad = 8'h08;
        #1;
        check_eq("ch3_drive1",    32'(gpio_pad), 32'hFF);
        check_eq("ch3_inpad1",    32'(io_inpad), 32'hFF);

        // Readback after done: tail replays image, shadow and done unchanged
        io_outpad = 8'h00;
        #1;
        readback(rb);
        check_eq("readback_001",  32'(rb),       32'h000200);
        check_eq("rb_pads_kept",  32'(gpio_pad), 32'hF7);
        check_eq("rb_done_kept",  32'(cfg_done), 32'h1);

        // ch3 = 101: inverted drive
        configure(24'h000A00);
        io_outpad = 8'h08;
        #1;
        check_eq("ch3_inv_pad",   32'(gpio_pad), 32'hF7);
        check_eq("ch3_inv_inpad", 32'(io_inpad), 32'hFF);

        // Restart together with a shift: shift ignored, counter from zero
        cfg_restart   = 1'b1;
        ccff_shift_en = 1'b1;
        ccff_head     = 1'b1;
        tick();
        cfg_restart   = 1'b0;
        ccff_shift_en = 1'b0;
        ccff_head     = 1'b0;
        check_eq("rs_done_clr",   32'(cfg_done), 32'h0);
        check_eq("rs_pads_z",     32'(gpio_pad), 32'hFF);
        rb = '0;
        for (int i = 23; i >= 0; i--) begin
            rb[i] = ccff_tail;
            if (i == 0) check_eq("rs_done_at_23", 32'(cfg_done), 32'h0);
            shift_bit(1'b0);
        end
        check_eq("rs_chain_kept", 32'(rb),       32'h000A00);
        check_eq("rs_done_at_24", 32'(cfg_done), 32'h1);
        tick();

        // ch5 = 010 (synchronised), ch4 = 000 (direct), both externally driven
        io_outpad = 8'h00;
        ext_en    = 8'h30;
        ext_val   = 8'h00;
        configure(24'h010000);
        check_eq("sync_low_pre",  32'(io_inpad[5:4]), 32'h0);
        ext_val = 8'h30;
        #1;
        check_eq("direct_same",   32'(io_inpad[4]), 32'h1);
        check_eq("sync_edge0",    32'(io_inpad[5]), 32'h0);
        tick();
        check_eq("sync_edge1",    32'(io_inpad[5]), 32'h0);
        tick();
        check_eq("sync_edge2",    32'(io_inpad[5]), 32'h1);
        ext_en  = 8'h00;
        ext_val = 8'h00;

        // GPIN through two stages, GPOUT combinational
        gpin_pad = 8'hA5;
        tick();
        check_eq("gpin_edge1",    32'(gp_inpad), 32'h00);
        tick();
        check_eq("gpin_edge2",    32'(gp_inpad), 32'hA5);
        gp_outpad = 8'h3C;
        #1;
        check_eq("gpout_comb",    32'(gpout_pad), 32'h3C);

        // Asynchronous reset at shift count 10 after a complete configuration
        configure(24'h000200);
        io_outpad = 8'h00;
        check_eq("pre_rst_pad",   32'(gpio_pad), 32'hF7);
        for (int i = 0; i < 10; i++) shift_bit(1'b1);
        check_eq("pre_rst_done",  32'(cfg_done), 32'h1);
        #2;
        pReset = 1'b0;
        #1;
        check_eq("arst_done",     32'(cfg_done),  32'h0);
        check_eq("arst_gp_inpad", 32'(gp_inpad),  32'h00);
        check_eq("arst_io_inpad", 32'(io_inpad),  32'h00);
        check_eq("arst_pads_z",   32'(gpio_pad),  32'hFF);
        check_eq("arst_tail",     32'(ccff_tail), 32'h0);
        #2;
        pReset = 1'b1;
        tick();
        for (int i = 0; i < 23; i++) shift_bit(1'b1);
        check_eq("post_rst_23",   32'(cfg_done), 32'h0);
        shift_bit(1'b1);
        check_eq("post_rst_24",   32'(cfg_done), 32'h1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
